ysyx_22050019_icache_rd_slave: RTL and testbench

Memory-side read responder for the instruction-cache refill port. It accepts one read-address request (address plus beat count), fetches each 64-bit beat from a single-port synchronous SRAM-style backing memory, and returns the beats on a valid/ready read-data channel with response code and last flag. It sits between the icache's `cache_ar_*`/`cache_r_*` master signals and the instruction memory. It supports one outstanding burst at a time.

---
 rtl/ysyx_22050019_icache_rd_slave_if.sv | 27 ++
 rtl/ysyx_22050019_icache_rd_slave.sv | 134 +++++++++++++
 tb/tb_ysyx_22050019_icache_rd_slave.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_22050019_icache_rd_slave_if.sv
// Read-address / read-data channel pair between the icache refill master and the memory-side responder.
interface ysyx_22050019_icache_rd_slave_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned LEN_WIDTH  = 8
);
    logic                  ar_valid_i;
    logic                  ar_ready_o;
    logic [ADDR_WIDTH-1:0] ar_addr_i;
    logic [LEN_WIDTH-1:0]  ar_len_i;

    logic                  r_valid_o;
    logic                  r_ready_i;
    logic [DATA_WIDTH-1:0] r_data_o;
    logic [1:0]            r_resp_o;
    logic                  r_last_o;

    modport master (
        output ar_valid_i, ar_addr_i, ar_len_i, r_ready_i,
        input  ar_ready_o, r_valid_o, r_data_o, r_resp_o, r_last_o
    );

    modport slave (
        input  ar_valid_i, ar_addr_i, ar_len_i, r_ready_i,
        output ar_ready_o, r_valid_o, r_data_o, r_resp_o, r_last_o
    );
endinterface

// File: rtl/ysyx_22050019_icache_rd_slave.sv
// Memory-side burst read responder for the icache refill port, one outstanding burst at a time.
// Define ICACHE_RD_SLAVE_WRAP_EN for critical-word-first wrapping bursts (len+1 in {2,4,8,16}).
module ysyx_22050019_icache_rd_slave #(
    parameter int unsigned           ADDR_WIDTH = 32,
    parameter int unsigned           DATA_WIDTH = 64,
    parameter int unsigned           LEN_WIDTH  = 8,
    parameter logic [ADDR_WIDTH-1:0] MEM_BASE   = ADDR_WIDTH'(32'h8000_0000),
    parameter logic [ADDR_WIDTH-1:0] MEM_SIZE   = ADDR_WIDTH'(32'h0800_0000)
) (
    input  logic                  clk,
    input  logic                  rst,
    ysyx_22050019_icache_rd_slave_if.slave bus,
    output logic                  mem_req_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i
);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [LEN_WIDTH-1:0]  len_q;
    logic [LEN_WIDTH-1:0]  cnt_q;
    logic                  ar_ready_q;
    logic                  r_valid_q;
    logic [DATA_WIDTH-1:0] r_data_q;
    logic [1:0]            r_resp_q;
    logic                  r_last_q;

    // Address of beat n of a burst starting at an 8-byte aligned address.
    function automatic logic [ADDR_WIDTH-1:0] beat_addr(input logic [ADDR_WIDTH-1:0] start,
                                                       input logic [LEN_WIDTH-1:0]  len,
                                                       input logic [LEN_WIDTH-1:0]  n);
        logic [ADDR_WIDTH-1:0] incr;
        logic [ADDR_WIDTH-1:0] mask;
        logic                  wrap;
        incr = start + (ADDR_WIDTH'(n) << 3);
        mask = ADDR_WIDTH'({len, 3'b111});
`ifdef ICACHE_RD_SLAVE_WRAP_EN
        wrap = (len == LEN_WIDTH'(1)) || (len == LEN_WIDTH'(3)) ||
               (len == LEN_WIDTH'(7)) || (len == LEN_WIDTH'(15));
`else
        wrap = 1'b0;
`endif
        beat_addr = wrap ? ((start & ~mask) | (incr & mask)) : incr;
    endfunction

    function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
        in_range = (a - MEM_BASE) < MEM_SIZE;
    endfunction

    logic [ADDR_WIDTH-1:0] start_aligned;
    logic [ADDR_WIDTH-1:0] first_addr;
    logic [ADDR_WIDTH-1:0] next_addr;
    logic [LEN_WIDTH-1:0]  cnt_next;

    assign start_aligned = bus.ar_addr_i & ~ADDR_WIDTH'(7);
    assign first_addr    = beat_addr(start_aligned, bus.ar_len_i, '0);
    assign cnt_next      = cnt_q + LEN_WIDTH'(1);
    assign next_addr     = beat_addr(addr_q, len_q, cnt_next);

    // mem_req_o/mem_addr_o are loaded on entry to S_REQ, so they are pure flop outputs while there.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            addr_q     <= '0;
            len_q      <= '0;
            cnt_q      <= '0;
            ar_ready_q <= 1'b1;
            r_valid_q  <= 1'b0;
            r_data_q   <= '0;
            r_resp_q   <= RESP_OKAY;
            r_last_q   <= 1'b0;
            mem_req_o  <= 1'b0;
            mem_addr_o <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.ar_valid_i && ar_ready_q) begin
                        addr_q     <= start_aligned;
                        len_q      <= bus.ar_len_i;
                        cnt_q      <= '0;
                        ar_ready_q <= 1'b0;
                        mem_req_o  <= in_range(first_addr);
                        if (in_range(first_addr)) mem_addr_o <= first_addr;
                        state      <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (mem_req_o) begin
                        mem_req_o <= 1'b0;
                        state     <= S_WAIT;
                    end else begin
                        r_data_q  <= '0;
                        r_resp_q  <= RESP_SLVERR;
                        r_valid_q <= 1'b1;
                        r_last_q  <= (cnt_q == len_q);
                        state     <= S_RESP;
                    end
                end
                S_WAIT: begin
                    r_data_q  <= mem_rdata_i;
                    r_resp_q  <= RESP_OKAY;
                    r_valid_q <= 1'b1;
                    r_last_q  <= (cnt_q == len_q);
                    state     <= S_RESP;
                end
                S_RESP: begin
                    if (bus.r_ready_i) begin
                        r_valid_q <= 1'b0;
                        if (r_last_q) begin
                            ar_ready_q <= 1'b1;
                            state      <= S_IDLE;
                        end else begin
                            cnt_q     <= cnt_next;
                            mem_req_o <= in_range(next_addr);
                            if (in_range(next_addr)) mem_addr_o <= next_addr;
                            state     <= S_REQ;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.ar_ready_o = ar_ready_q;
    assign bus.r_valid_o  = r_valid_q;
    assign bus.r_data_o   = r_data_q;
    assign bus.r_resp_o   = r_resp_q;
    assign bus.r_last_o   = r_last_q;
endmodule

// File: tb/tb_ysyx_22050019_icache_rd_slave.sv
// Directed bench for the icache refill read responder, with a one-cycle-latency backing memory model.
module tb_ysyx_22050019_icache_rd_slave;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [63:0] mem_rdata = 64'h0;

    int n_cmp = 0;
    int n_err = 0;

    ysyx_22050019_icache_rd_slave_if bus ();

    ysyx_22050019_icache_rd_slave dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .mem_req_o   (mem_req),
        .mem_addr_o  (mem_addr),
        .mem_rdata_i (mem_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] mem_word(input logic [31:0] a);
        mem_word = (a == 32'h8000_0100) ? 64'hDEAD_BEEF_0123_4567 : {a, ~a};
    endfunction

    // Data is only valid in the cycle right after a request.
    always @(posedge clk) mem_rdata <= mem_req ? mem_word(mem_addr) : 64'h0BAD_0BAD_0BAD_0BAD;

    logic [63:0] bd [16];
    logic [1:0]  br [16];
    logic        bl [16];
    int          nbeats, done_cyc, first_valid, hold_bad, req_during_valid;
    logic [31:0] mem_log [$];

    // Issue one request and collect its beats; cycles are counted in edges after acceptance.
    task automatic run_burst(input logic [31:0] addr, input logic [7:0] len, input int stall_n);
        int          cyc;
        int          stall_left;
        logic        have;
        logic [63:0] sd;
        logic [1:0]  sr;
        logic        sl;
        nbeats = 0; done_cyc = -1; first_valid = -1; hold_bad = 0; req_during_valid = 0;
        mem_log.delete();
        stall_left = stall_n; have = 1'b0; sd = '0; sr = '0; sl = 1'b0;
        @(negedge clk);
        bus.ar_valid_i = 1'b1; bus.ar_addr_i = addr; bus.ar_len_i = len; bus.r_ready_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.ar_valid_i = 1'b0; bus.ar_addr_i = 32'hFFFF_FFF0; bus.ar_len_i = 8'hFF;
        cyc = 0;
        while (cyc < 100 && done_cyc < 0) begin
            if (mem_req) mem_log.push_back(mem_addr);
            bus.r_ready_i = 1'b1;
            if (bus.r_valid_o) begin
                if (first_valid < 0) first_valid = cyc;
                if (mem_req) req_during_valid++;
                if (!have) begin
                    sd = bus.r_data_o; sr = bus.r_resp_o; sl = bus.r_last_o; have = 1'b1;
                end else if (bus.r_data_o !== sd || bus.r_resp_o !== sr || bus.r_last_o !== sl) begin
                    hold_bad++;
                end
                if (nbeats == 0 && stall_left > 0) begin
                    bus.r_ready_i = 1'b0;
                    stall_left--;
                end else begin
                    if (nbeats < 16) begin
                        bd[nbeats] = bus.r_data_o; br[nbeats] = bus.r_resp_o; bl[nbeats] = bus.r_last_o;
                    end
                    nbeats++;
                    have = 1'b0;
                    if (bus.r_last_o) done_cyc = cyc + 1;
                end
            end
            @(posedge clk);
            cyc++;
            @(negedge clk);
        end
        bus.r_ready_i = 1'b1;
    endtask

    task automatic test_reset();
        n_cmp++; if (bus.ar_ready_o !== 1'b1) begin n_err++; $display("FAIL reset_ar_ready: got %b want 1", bus.ar_ready_o); end
        n_cmp++; if (bus.r_valid_o !== 1'b0) begin n_err++; $display("FAIL reset_r_valid: got %b want 0", bus.r_valid_o); end
        n_cmp++; if (bus.r_data_o !== 64'h0) begin n_err++; $display("FAIL reset_r_data: got %h want 0", bus.r_data_o); end
        n_cmp++; if (bus.r_resp_o !== 2'b00) begin n_err++; $display("FAIL reset_r_resp: got %b want 00", bus.r_resp_o); end
        n_cmp++; if (bus.r_last_o !== 1'b0) begin n_err++; $display("FAIL reset_r_last: got %b want 0", bus.r_last_o); end
        n_cmp++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL reset_mem_req: got %b want 0", mem_req); end
        n_cmp++; if (mem_addr !== 32'h0) begin n_err++; $display("FAIL reset_mem_addr: got %h want 0", mem_addr); end
    endtask

    task automatic test_single_beat();
        run_burst(32'h8000_0100, 8'd0, 0);
        n_cmp++; if (nbeats !== 1) begin n_err++; $display("FAIL single_nbeats: got %0d want 1", nbeats); end
        n_cmp++; if (bd[0] !== 64'hDEAD_BEEF_0123_4567) begin n_err++; $display("FAIL single_data: got %h want deadbeef01234567", bd[0]); end
        n_cmp++; if (br[0] !== 2'b00) begin n_err++; $display("FAIL single_resp: got %b want 00", br[0]); end
        n_cmp++; if (bl[0] !== 1'b1) begin n_err++; $display("FAIL single_last: got %b want 1", bl[0]); end
        n_cmp++; if (first_valid !== 2) begin n_err++; $display("FAIL single_valid_lat: got %0d want 2", first_valid); end
        n_cmp++; if (done_cyc !== 3) begin n_err++; $display("FAIL single_cycles: got %0d want 3", done_cyc); end
        n_cmp++; if (mem_log.size() !== 1) begin n_err++; $display("FAIL single_req_count: got %0d want 1", mem_log.size()); end
        n_cmp++; if (mem_addr !== 32'h8000_0100) begin n_err++; $display("FAIL single_mem_addr: got %h want 80000100", mem_addr); end
        n_cmp++; if (bus.ar_ready_o !== 1'b1) begin n_err++; $display("FAIL single_ar_ready: got %b want 1", bus.ar_ready_o); end
    endtask

    task automatic test_refill();
        run_burst(32'h8000_0013, 8'd1, 0);
        n_cmp++; if (nbeats !== 2) begin n_err++; $display("FAIL refill_nbeats: got %0d want 2", nbeats); end
        n_cmp++; if (mem_log.size() !== 2) begin n_err++; $display("FAIL refill_req_count: got %0d want 2", mem_log.size()); end
        else begin
            n_cmp++; if (mem_log[0] !== 32'h8000_0010) begin n_err++; $display("FAIL refill_addr0: got %h want 80000010", mem_log[0]); end
            n_cmp++; if (mem_log[1] !== 32'h8000_0018) begin n_err++; $display("FAIL refill_addr1: got %h want 80000018", mem_log[1]); end
        end
        n_cmp++; if (bd[0] !== 64'h8000_0010_7FFF_FFEF) begin n_err++; $display("FAIL refill_data0: got %h want 800000107fffffef", bd[0]); end
        n_cmp++; if (bd[1] !== 64'h8000_0018_7FFF_FFE7) begin n_err++; $display("FAIL refill_data1: got %h want 800000187fffffe7", bd[1]); end
        n_cmp++; if (bl[0] !== 1'b0 || bl[1] !== 1'b1) begin n_err++; $display("FAIL refill_last: got %b%b want 01", bl[0], bl[1]); end
        n_cmp++; if (done_cyc !== 6) begin n_err++; $display("FAIL refill_cycles: got %0d want 6", done_cyc); end
        n_cmp++; if (bus.ar_ready_o !== 1'b1) begin n_err++; $display("FAIL refill_ar_ready: got %b want 1", bus.ar_ready_o); end
    endtask

    task automatic test_backpressure();
        run_burst(32'h8000_0013, 8'd1, 3);
        n_cmp++; if (done_cyc !== 9) begin n_err++; $display("FAIL bp_cycles: got %0d want 9", done_cyc); end
        n_cmp++; if (hold_bad !== 0) begin n_err++; $display("FAIL bp_hold: got %0d changes want 0", hold_bad); end
        n_cmp++; if (req_during_valid !== 0) begin n_err++; $display("FAIL bp_req_in_stall: got %0d want 0", req_during_valid); end
        n_cmp++; if (bd[0] !== 64'h8000_0010_7FFF_FFEF) begin n_err++; $display("FAIL bp_data0: got %h want 800000107fffffef", bd[0]); end
        n_cmp++; if (bd[1] !== 64'h8000_0018_7FFF_FFE7) begin n_err++; $display("FAIL bp_data1: got %h want 800000187fffffe7", bd[1]); end
    endtask

    task automatic test_error();
        run_burst(32'h0000_1000, 8'd1, 0);
        n_cmp++; if (nbeats !== 2) begin n_err++; $display("FAIL err_nbeats: got %0d want 2", nbeats); end
        n_cmp++; if (br[0] !== 2'b10 || br[1] !== 2'b10) begin n_err++; $display("FAIL err_resp: got %b %b want 10 10", br[0], br[1]); end
        n_cmp++; if (bd[0] !== 64'h0 || bd[1] !== 64'h0) begin n_err++; $display("FAIL err_data: got %h %h want 0 0", bd[0], bd[1]); end
        n_cmp++; if (mem_log.size() !== 0) begin n_err++; $display("FAIL err_mem_req: got %0d requests want 0", mem_log.size()); end
        n_cmp++; if (first_valid !== 1) begin n_err++; $display("FAIL err_valid_lat: got %0d want 1", first_valid); end
        n_cmp++; if (done_cyc !== 4) begin n_err++; $display("FAIL err_cycles: got %0d want 4", done_cyc); end
    endtask

    task automatic test_window_end();
        run_burst(32'h87FF_FFF8, 8'd1, 0);
        n_cmp++; if (br[0] !== 2'b00 || br[1] !== 2'b10) begin n_err++; $display("FAIL cross_resp: got %b %b want 00 10", br[0], br[1]); end
        n_cmp++; if (bd[0] !== 64'h87FF_FFF8_7800_0007) begin n_err++; $display("FAIL cross_data0: got %h want 87fffff878000007", bd[0]); end
        n_cmp++; if (bd[1] !== 64'h0) begin n_err++; $display("FAIL cross_data1: got %h want 0", bd[1]); end
        n_cmp++; if (mem_log.size() !== 1) begin n_err++; $display("FAIL cross_req_count: got %0d want 1", mem_log.size()); end
        n_cmp++; if (done_cyc !== 5) begin n_err++; $display("FAIL cross_cycles: got %0d want 5", done_cyc); end
    endtask

    task automatic test_wrap();
        logic [31:0] exp1;
`ifdef ICACHE_RD_SLAVE_WRAP_EN
        exp1 = 32'h8000_0000;
`else
        exp1 = 32'h8000_0010;
`endif
        run_burst(32'h8000_0008, 8'd1, 0);
        n_cmp++; if (mem_log.size() !== 2) begin n_err++; $display("FAIL wrap_req_count: got %0d want 2", mem_log.size()); end
        else begin
            n_cmp++; if (mem_log[0] !== 32'h8000_0008) begin n_err++; $display("FAIL wrap_addr0: got %h want 80000008", mem_log[0]); end
            n_cmp++; if (mem_log[1] !== exp1) begin n_err++; $display("FAIL wrap_addr1: got %h want %h", mem_log[1], exp1); end
        end
        n_cmp++; if (bd[1] !== {exp1, ~exp1}) begin n_err++; $display("FAIL wrap_data1: got %h want %h", bd[1], {exp1, ~exp1}); end
    endtask

    task automatic test_reset_mid();
        int seen;
        @(negedge clk);
        bus.ar_valid_i = 1'b1; bus.ar_addr_i = 32'h8000_0100; bus.ar_len_i = 8'd1;
        @(posedge clk);
        @(negedge clk);
        bus.ar_valid_i = 1'b0;
        @(posedge clk);
        @(negedge clk);
        n_cmp++; if (mem_addr !== 32'h8000_0100) begin n_err++; $display("FAIL rstmid_pre_addr: got %h want 80000100", mem_addr); end
        rst = 1'b0;
        #1;
        n_cmp++; if (bus.ar_ready_o !== 1'b1) begin n_err++; $display("FAIL rstmid_ar_ready: got %b want 1", bus.ar_ready_o); end
        n_cmp++; if (mem_addr !== 32'h0) begin n_err++; $display("FAIL rstmid_mem_addr: got %h want 0", mem_addr); end
        n_cmp++; if (mem_req !== 1'b0 || bus.r_valid_o !== 1'b0) begin n_err++; $display("FAIL rstmid_req_valid: got %b%b want 00", mem_req, bus.r_valid_o); end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus.r_valid_o || mem_req || !bus.ar_ready_o) seen++;
        end
        n_cmp++; if (seen !== 0) begin n_err++; $display("FAIL rstmid_stale: got %0d busy cycles want 0", seen); end
        run_burst(32'h8000_0013, 8'd1, 0);
        n_cmp++; if (done_cyc !== 6) begin n_err++; $display("FAIL rstmid_after_cycles: got %0d want 6", done_cyc); end
        n_cmp++; if (bd[1] !== 64'h8000_0018_7FFF_FFE7) begin n_err++; $display("FAIL rstmid_after_data1: got %h want 800000187fffffe7", bd[1]); end
    endtask

    initial begin
        bus.ar_valid_i = 1'b0;
        bus.ar_addr_i  = 32'h0;
        bus.ar_len_i   = 8'h0;
        bus.r_ready_i  = 1'b1;
        repeat (2) @(negedge clk);
        test_reset();
        rst = 1'b1;
        @(negedge clk);
        test_single_beat();
        test_refill();
        test_backpressure();
        test_error();
        test_window_end();
        test_wrap();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
